// File: rtl/rom_fetch_arbiter_pkg.sv
// rtl/rom_fetch_arbiter_pkg.sv - shared FSM encodings and port ids for the ROM fetch arbiter
package rom_fetch_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic P_FETCH = 1'b0;
  localparam logic P_DBG   = 1'b1;

endpackage

// File: rtl/rom_fetch_arbiter_rr_arb2.sv
// rtl/rom_fetch_arbiter_rr_arb2.sv - combinational 2-way round-robin picker
// Purpose: picks one of two requesters, preferring the one not granted last time.
// Ports:
//   i_req0, i_req1   request lines
//   i_last_gnt       id of the port granted most recently
//   o_gnt_valid      at least one request present
//   o_gnt_id         id of the winning port (meaningful when o_gnt_valid)
module rom_fetch_arbiter_rr_arb2
  import rom_fetch_arbiter_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  always_comb begin
    o_gnt_valid = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_id = (i_last_gnt == P_FETCH) ? P_DBG : P_FETCH;
    end else begin
      o_gnt_id = i_req1 ? P_DBG : P_FETCH;
    end
  end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// rtl/rom_fetch_arbiter.sv - round-robin sharing of the rom32 port between fetch and debug readers
// Purpose: grants one requester at a time, registers the ROM address, latches the ROM data
//   two cycles later and returns it with an error flag for unaligned/out-of-window accesses.
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req0/addr0/ack0/rvalid0   fetch port: request+address in, accept and response-valid pulses out
//   req1/addr1/ack1/rvalid1   debug port: same handshake as the fetch port
//   rdata, rerr               shared response data and error, qualified by rvalidN
//   rom_addr, rom_data        registered address to rom32, combinational data back
//   busy                      high whenever a transaction is in flight
module rom_fetch_arbiter
  import rom_fetch_arbiter_pkg::*;
#(
  parameter logic [24:0] BASE_ADDRESS = 25'd0,
  parameter logic [31:0] ERR_DATA     = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        ack0,
  output logic        rvalid0,
  input  logic        req1,
  input  logic [31:0] addr1,
  output logic        ack1,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic        rerr,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_grant;
  logic        w_gnt_valid;
  logic        w_gnt_id;
  logic [31:0] w_addr_sel;
  logic        w_err;

  logic        r_last_gnt;
  logic        r_owner;
  logic        r_err_q;
  logic [31:0] r_rom_addr;
  logic [31:0] r_rdata;
  logic        r_rerr;
  logic        r_rvalid0;
  logic        r_rvalid1;

  rom_fetch_arbiter_rr_arb2 u_arb (
    .i_req0      (req0),
    .i_req1      (req1),
    .i_last_gnt  (r_last_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: w_state_nxt = ST_RESP;
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_addr_sel = (w_gnt_id == P_DBG) ? addr1 : addr0;
  assign w_err      = (w_addr_sel[1:0] != 2'b00) || (w_addr_sel[31:7] != BASE_ADDRESS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_gnt <= P_DBG;
      r_owner    <= P_FETCH;
      r_err_q    <= 1'b0;
      r_rom_addr <= 32'h0;
      r_rdata    <= 32'h0;
      r_rerr     <= 1'b0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
    end else begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      if (w_grant) begin
        // Errored accesses still present a word-aligned address so rom32 never sees a bad one.
        r_rom_addr <= {w_addr_sel[31:2], (w_err ? 2'b00 : w_addr_sel[1:0])};
        r_owner    <= w_gnt_id;
        r_last_gnt <= w_gnt_id;
        r_err_q    <= w_err;
      end
      if (r_state == ST_RESP) begin
        r_rdata   <= r_err_q ? ERR_DATA : rom_data;
        r_rerr    <= r_err_q;
        r_rvalid0 <= (r_owner == P_FETCH);
        r_rvalid1 <= (r_owner == P_DBG);
      end
    end
  end

  assign ack0     = w_grant && (w_gnt_id == P_FETCH);
  assign ack1     = w_grant && (w_gnt_id == P_DBG);
  assign rvalid0  = r_rvalid0;
  assign rvalid1  = r_rvalid1;
  assign rdata    = r_rdata;
  assign rerr     = r_rerr;
  assign rom_addr = r_rom_addr;
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
// tb/tb_rom_fetch_arbiter.sv - directed self-checking bench for rom_fetch_arbiter
module tb_rom_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0, req1;
  logic [31:0] addr0, addr1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic        rerr;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  // Small stand-in for rom32: first three words hold the program image.
  always_comb begin
    case (rom_addr)
      32'h0000_0000: rom_data = 32'h8C02_0004;
      32'h0000_0004: rom_data = 32'h8C03_0008;
      32'h0000_0008: rom_data = 32'h8C04_0014;
      default:       rom_data = {16'hFFFF, rom_addr[15:0]};
    endcase
  end

  rom_fetch_arbiter #(
    .BASE_ADDRESS (25'd0),
    .ERR_DATA     (32'h0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req0     (req0),
    .addr0    (addr0),
    .ack0     (ack0),
    .rvalid0  (rvalid0),
    .req1     (req1),
    .addr1    (addr1),
    .ack1     (ack1),
    .rvalid1  (rvalid1),
    .rdata    (rdata),
    .rerr     (rerr),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic ack_of(input int p);
    return (p == 0) ? ack0 : ack1;
  endfunction

  function automatic logic rvalid_of(input int p);
    return (p == 0) ? rvalid0 : rvalid1;
  endfunction

  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      check("ack_excl",    {31'b0, ack0 & ack1},       32'h0);
      check("rvalid_excl", {31'b0, rvalid0 & rvalid1}, 32'h0);
    end
  end

  task automatic wait_ack(input int p, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (ack_of(p)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic single(input int p, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic exp_e, input string tag);
    bit ok;
    @(negedge clk);
    if (p == 0) begin req0 = 1'b1; addr0 = a; end
    else        begin req1 = 1'b1; addr1 = a; end
    #1;
    wait_ack(p, ok);
    check({tag, "_ack"}, {31'b0, ok}, 32'h1);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    #1;
    check({tag, "_rv_t1"},   {31'b0, rvalid0 | rvalid1}, 32'h0);
    check({tag, "_busy_t1"}, {31'b0, busy},              32'h1);
    check({tag, "_romaddr"}, rom_addr,                   {a[31:2], 2'b00});
    @(negedge clk);
    #1;
    check({tag, "_rv_t2"},   {31'b0, rvalid0 | rvalid1}, 32'h0);
    @(negedge clk);
    #1;
    check({tag, "_rvalid"},  {31'b0, rvalid_of(p)},      32'h1);
    check({tag, "_rdata"},   rdata,                      exp_d);
    check({tag, "_rerr"},    {31'b0, rerr},              {31'b0, exp_e});
    check({tag, "_busy_t3"}, {31'b0, busy},              32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int t0, t1, nrv0, nrv1;
    logic [31:0] d0, d1;
    int gseq[$];
    int gcyc[$];

    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = 32'h0; addr1 = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy",    {31'b0, busy},    32'h0);
    check("rst_romaddr", rom_addr,         32'h0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_rerr",    {31'b0, rerr},    32'h0);
    check("rst_ack",     {30'b0, ack1, ack0},       32'h0);
    check("rst_rvalid",  {30'b0, rvalid1, rvalid0}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // T2 single fetch
    single(0, 32'h0, 32'h8C02_0004, 1'b0, "t2");

    // T1 reset mid-READ
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h4;
    #1;
    wait_ack(0, ok);
    check("t1_ack", {31'b0, ok}, 32'h1);
    @(negedge clk);
    req0 = 1'b0;
    #1;
    check("t1_busy_read", {31'b0, busy}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_busy",    {31'b0, busy}, 32'h0);
    check("t1_romaddr", rom_addr,      32'h0);
    check("t1_rdata",   rdata,         32'h0);
    check("t1_rerr",    {31'b0, rerr}, 32'h0);
    check("t1_outs",    {28'b0, ack1, ack0, rvalid1, rvalid0}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    nrv0 = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      if (rvalid0 || rvalid1) nrv0++;
    end
    check("t1_no_rvalid", nrv0, 0);

    // T5a unaligned debug read
    single(1, 32'h6, 32'h0, 1'b1, "t5a");

    // T3 contention: port 0 first (last grant was port 1)
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h4;
    req1 = 1'b1; addr1 = 32'h8;
    #1;
    t0 = -1; t1 = -1; nrv0 = 0; nrv1 = 0; d0 = 32'h0; d1 = 32'h0;
    for (int c = 0; c < 12; c++) begin
      if (ack0 && t0 < 0) t0 = c;
      if (ack1 && t1 < 0) t1 = c;
      if (rvalid0) begin nrv0++; d0 = rdata; end
      if (rvalid1) begin nrv1++; d1 = rdata; end
      @(negedge clk);
      if (t0 >= 0) req0 = 1'b0;
      if (t1 >= 0) req1 = 1'b0;
      #1;
    end
    check("t3_ack0_cycle", t0,   0);
    check("t3_ack1_cycle", t1,   3);
    check("t3_data0",      d0,   32'h8C03_0008);
    check("t3_data1",      d1,   32'h8C04_0014);
    check("t3_nrv0",       nrv0, 1);
    check("t3_nrv1",       nrv1, 1);

    // T4 fairness: both held 12 cycles
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h0;
    req1 = 1'b1; addr1 = 32'h8;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (ack0) begin gseq.push_back(0); gcyc.push_back(c); end
      if (ack1) begin gseq.push_back(1); gcyc.push_back(c); end
      @(negedge clk);
      if (c == 11) begin req0 = 1'b0; req1 = 1'b0; end
      #1;
    end
    check("t4_ngrants", gseq.size(), 4);
    if (gseq.size() == 4) begin
      check("t4_g0", gseq[0], 0);
      check("t4_g1", gseq[1], 1);
      check("t4_g2", gseq[2], 0);
      check("t4_g3", gseq[3], 1);
      check("t4_wait1",    gcyc[1],           3);
      check("t4_p0_gap",   gcyc[2] - gcyc[0], 6);
      check("t4_p1_gap",   gcyc[3] - gcyc[1], 6);
    end
    repeat (4) @(negedge clk);

    // T5b out-of-window fetch
    single(0, 32'h80, 32'h0, 1'b0 | 1'b1, "t5b");

    // T6 late req1 during port 0 RESP
    @(negedge clk);
    req0 = 1'b1; addr0 = 32'h0;
    #1;
    wait_ack(0, ok);
    check("t6_ack0", {31'b0, ok}, 32'h1);
    @(negedge clk);
    req0 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; addr1 = 32'h8;
    #1;
    check("t6_no_ack1_resp", {31'b0, ack1}, 32'h0);
    @(negedge clk);
    #1;
    check("t6_rvalid0", {31'b0, rvalid0}, 32'h1);
    check("t6_ack1",    {31'b0, ack1},    32'h1);
    check("t6_rdata0",  rdata,            32'h8C02_0004);
    nrv0 = 0; nrv1 = 0; d1 = 32'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) req1 = 1'b0;
      #1;
      if (rvalid0) nrv0++;
      if (rvalid1) begin nrv1++; d1 = rdata; end
    end
    check("t6_no_second_rv0", nrv0, 0);
    check("t6_nrv1",          nrv1, 1);
    check("t6_rdata1",        d1,   32'h8C04_0014);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
